// File: rtl/dma_byte_sequencer.sv
// dma_byte_sequencer: byte-granular DMA walker between the channel streams
// and the AXI byte I/O master. Memory write (write=1) pulls bytes from the
// in_* stream; memory read (write=0) pushes read bytes onto the out_* stream.
// Optional statistics outputs are built when DMA_BYTE_SEQ_STATS_EN is defined.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// WAIT_DATA | memory write: waiting for a channel byte (in_ready=1)
// ISSUE     | waiting for x_busy=0 to pulse x_start
// WAIT_DONE | byte I/O in flight, waiting for x_done
// DELIVER   | memory read: holding out_data until the channel takes it
// FINISH    | one cycle before IDLE; emits the done pulse
module dma_byte_sequencer #(
  parameter int ADDR_WIDTH  = 32,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   start,
  input  logic                   write,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [COUNT_WIDTH-1:0] count,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH-1:0] res_count,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [7:0]             out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  input  logic                   x_busy,
  output logic                   x_write,
  output logic [ADDR_WIDTH-1:0]  x_addr,
  output logic [7:0]             x_data_write,
  output logic                   x_start,
  input  logic [7:0]             x_data_read,
  input  logic                   x_done
`ifdef DMA_BYTE_SEQ_STATS_EN
  ,
  output logic [31:0]            xfer_total,
  output logic [7:0]             abort_count
`endif
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_DATA = 3'd1,
    ISSUE     = 3'd2,
    WAIT_DONE = 3'd3,
    DELIVER   = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t                 state_q, state_d;
  logic                   aborted_q, aborted_d;
  logic                   busy_d, done_d, out_valid_d, x_write_d, x_start_d;
  logic [COUNT_WIDTH-1:0] res_count_d;
  logic [7:0]             out_data_d, x_data_write_d;
  logic [ADDR_WIDTH-1:0]  x_addr_d;
  logic                   advance;

  assign in_ready = (state_q == WAIT_DATA);

  // Next-state and next-output computation; ADVANCE is folded in at the end.
  always_comb begin
    state_d        = state_q;
    aborted_d      = aborted_q;
    busy_d         = busy;
    done_d         = 1'b0;
    res_count_d    = res_count;
    out_data_d     = out_data;
    out_valid_d    = out_valid;
    x_write_d      = x_write;
    x_addr_d       = x_addr;
    x_data_write_d = x_data_write;
    x_start_d      = 1'b0;
    advance        = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          x_write_d   = write;
          x_addr_d    = addr;
          res_count_d = count;
          busy_d      = 1'b1;
          aborted_d   = 1'b0;
          if (count == '0)  state_d = FINISH;
          else if (write)   state_d = WAIT_DATA;
          else              state_d = ISSUE;
        end
      end
      WAIT_DATA: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FINISH;
        end else if (in_valid) begin
          x_data_write_d = in_data;
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = FINISH;
        end else if (!x_busy) begin
          x_start_d = 1'b1;
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        // An abort here is remembered so the outstanding x_done is still
        // consumed before finishing, even if abort drops in the meantime.
        if (abort) aborted_d = 1'b1;
        if (x_done) begin
          if (abort || aborted_q) begin
            state_d = FINISH;
          end else if (x_write) begin
            advance = 1'b1;
          end else begin
            out_data_d  = x_data_read;
            out_valid_d = 1'b1;
            state_d     = DELIVER;
          end
        end
      end
      DELIVER: begin
        if (abort) begin
          out_valid_d = 1'b0;
          aborted_d   = 1'b1;
          state_d     = FINISH;
        end else if (out_valid && out_ready) begin
          out_valid_d = 1'b0;
          advance     = 1'b1;
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (advance) begin
      x_addr_d    = x_addr + ADDR_WIDTH'(1);
      res_count_d = res_count - COUNT_WIDTH'(1);
      if (res_count == COUNT_WIDTH'(1)) state_d = FINISH;
      else if (x_write)                 state_d = WAIT_DATA;
      else                              state_d = ISSUE;
    end
  end

  // State and registered outputs, synchronous active-low reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= IDLE;
      aborted_q    <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      res_count    <= '0;
      out_data     <= '0;
      out_valid    <= 1'b0;
      x_write      <= 1'b0;
      x_addr       <= '0;
      x_data_write <= '0;
      x_start      <= 1'b0;
    end else begin
      state_q      <= state_d;
      aborted_q    <= aborted_d;
      busy         <= busy_d;
      done         <= done_d;
      res_count    <= res_count_d;
      out_data     <= out_data_d;
      out_valid    <= out_valid_d;
      x_write      <= x_write_d;
      x_addr       <= x_addr_d;
      x_data_write <= x_data_write_d;
      x_start      <= x_start_d;
    end
  end

`ifdef DMA_BYTE_SEQ_STATS_EN
  // Saturating byte and abort counters, cleared only by reset.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      xfer_total  <= '0;
      abort_count <= '0;
    end else begin
      if (advance && (xfer_total != '1))
        xfer_total <= xfer_total + 32'd1;
      if ((state_q == FINISH) && aborted_q && (abort_count != '1))
        abort_count <= abort_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dma_byte_sequencer.sv
// Scoreboard bench for dma_byte_sequencer: directed transfers push expected
// byte I/O issues, delivered bytes and done results into queues; a monitor
// pops and compares whenever the DUT presents x_start, an out handshake or done.
module tb_dma_byte_sequencer;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start, write, abort;
  logic [31:0] addr;
  logic [7:0]  count;
  logic        busy, done;
  logic [7:0]  res_count;
  logic [7:0]  in_data;
  logic        in_valid, in_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_ready;
  logic        x_busy, x_write, x_start, x_done;
  logic [31:0] x_addr;
  logic [7:0]  x_data_write, x_data_read;
`ifdef DMA_BYTE_SEQ_STATS_EN
  logic [31:0] xfer_total;
  logic [7:0]  abort_count;
`endif

  always #5 aclk = ~aclk;

  dma_byte_sequencer dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .write(write),
    .addr(addr), .count(count), .abort(abort), .busy(busy), .done(done),
    .res_count(res_count), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .x_busy(x_busy), .x_write(x_write),
    .x_addr(x_addr), .x_data_write(x_data_write), .x_start(x_start),
    .x_data_read(x_data_read), .x_done(x_done)
`ifdef DMA_BYTE_SEQ_STATS_EN
    , .xfer_total(xfer_total), .abort_count(abort_count)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [7:0]  wd;
    logic        chk_wd;
    logic [7:0]  rc;
  } xs_t;

  xs_t        xs_q[$];
  logic [7:0] od_q[$];
  logic [7:0] done_q[$];
  logic [7:0] rd_q[$];
  int         resp_delay = 1;
  int         pass_cnt = 0;
  int         chk_cnt = 0;

  task automatic check(input string nm, input logic ok,
                       input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (ok) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic xs_t mk(input logic [31:0] a, input logic w,
                             input logic [7:0] d, input logic c, input logic [7:0] r);
    xs_t e;
    e.addr = a; e.wr = w; e.wd = d; e.chk_wd = c; e.rc = r;
    return e;
  endfunction

  // Monitor: compares every DUT-presented event against the scoreboard.
  initial begin
    xs_t e;
    logic [7:0] v;
    forever begin
      @(negedge aclk);
      if (x_start === 1'b1) begin
        if (xs_q.size() == 0) begin
          check("x_start_unexpected", 1'b0, {32'd0, x_addr}, 64'd0);
        end else begin
          e = xs_q.pop_front();
          check("x_start_addr", x_addr === e.addr, {32'd0, x_addr}, {32'd0, e.addr});
          check("x_start_write_rc", (x_write === e.wr) && (res_count === e.rc),
                {55'd0, x_write, res_count}, {55'd0, e.wr, e.rc});
          if (e.chk_wd)
            check("x_data_write", x_data_write === e.wd, {56'd0, x_data_write}, {56'd0, e.wd});
        end
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        if (od_q.size() == 0) begin
          check("out_unexpected", 1'b0, {56'd0, out_data}, 64'd0);
        end else begin
          v = od_q.pop_front();
          check("out_data", out_data === v, {56'd0, out_data}, {56'd0, v});
        end
      end
      if (done === 1'b1) begin
        if (done_q.size() == 0) begin
          check("done_unexpected", 1'b0, {56'd0, res_count}, 64'd0);
        end else begin
          v = done_q.pop_front();
          check("done_res_busy", (res_count === v) && (busy === 1'b0),
                {55'd0, busy, res_count}, {55'd0, 1'b0, v});
        end
      end
    end
  end

  // Byte I/O responder: answers each x_start with x_done after resp_delay cycles.
  initial begin
    x_done = 1'b0;
    x_data_read = 8'h00;
    forever begin
      @(negedge aclk);
      if (x_start === 1'b1) begin
        repeat (resp_delay) @(negedge aclk);
        x_data_read = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
        x_done = 1'b1;
        @(negedge aclk);
        x_done = 1'b0;
      end
    end
  end

  task automatic start_xfer(input logic w, input logic [31:0] a, input logic [7:0] c);
    write = w; addr = a; count = c; start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 1;
    while (done !== 1'b1 && lat < 300) begin
      @(negedge aclk);
      lat++;
    end
    if (done !== 1'b1) check("done_timeout", 1'b0, 64'd0, 64'd1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n;
    in_data = d; in_valid = 1'b1; n = 0;
    while (in_ready !== 1'b1 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    if (in_ready !== 1'b1) check("in_ready_timeout", 1'b0, 64'd0, 64'd1);
    @(negedge aclk);
    in_valid = 1'b0;
  endtask

  initial begin
    int lat, n, seen;
    aresetn = 1'b0; start = 1'b0; write = 1'b0; abort = 1'b0;
    addr = '0; count = '0; in_data = '0; in_valid = 1'b0;
    out_ready = 1'b1; x_busy = 1'b0;
    repeat (3) @(negedge aclk);
    check("reset_outputs",
          {busy, done, out_valid, x_start, in_ready, x_write} == 6'b0 &&
          res_count == 8'h00 && x_addr == 32'h0 && x_data_write == 8'h00 && out_data == 8'h00,
          {32'd0, x_addr}, 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // Memory read of three bytes.
    xs_q.push_back(mk(32'h1000, 1'b0, 8'h00, 1'b0, 8'd3));
    xs_q.push_back(mk(32'h1001, 1'b0, 8'h00, 1'b0, 8'd2));
    xs_q.push_back(mk(32'h1002, 1'b0, 8'h00, 1'b0, 8'd1));
    rd_q.push_back(8'hA1); rd_q.push_back(8'hB2); rd_q.push_back(8'hC3);
    od_q.push_back(8'hA1); od_q.push_back(8'hB2); od_q.push_back(8'hC3);
    done_q.push_back(8'd0);
    start_xfer(1'b0, 32'h1000, 8'd3);
    wait_done(lat);
    repeat (3) @(negedge aclk);

    // Memory write of two bytes with a gap between them.
    xs_q.push_back(mk(32'h2000, 1'b1, 8'h55, 1'b1, 8'd2));
    xs_q.push_back(mk(32'h2001, 1'b1, 8'h66, 1'b1, 8'd1));
    done_q.push_back(8'd0);
    start_xfer(1'b1, 32'h2000, 8'd2);
    send_byte(8'h55);
    repeat (5) @(negedge aclk);
    send_byte(8'h66);
    wait_done(lat);
    repeat (3) @(negedge aclk);

    // Zero-length transfer: done two cycles after start, no byte I/O.
    done_q.push_back(8'd0);
    start_xfer(1'b0, 32'h3000, 8'd0);
    wait_done(lat);
    check("count0_done_latency", lat == 2, 64'(lat), 64'd2);
    repeat (3) @(negedge aclk);

    // Address wrap from all-ones to zero.
    xs_q.push_back(mk(32'hFFFF_FFFF, 1'b0, 8'h00, 1'b0, 8'd2));
    xs_q.push_back(mk(32'h0000_0000, 1'b0, 8'h00, 1'b0, 8'd1));
    rd_q.push_back(8'h11); rd_q.push_back(8'h22);
    od_q.push_back(8'h11); od_q.push_back(8'h22);
    done_q.push_back(8'd0);
    start_xfer(1'b0, 32'hFFFF_FFFF, 8'd2);
    wait_done(lat);
    repeat (3) @(negedge aclk);

    // Abort during WAIT_DONE of the second byte of a four-byte read.
    resp_delay = 3;
    xs_q.push_back(mk(32'h3000, 1'b0, 8'h00, 1'b0, 8'd4));
    xs_q.push_back(mk(32'h3001, 1'b0, 8'h00, 1'b0, 8'd3));
    rd_q.push_back(8'hD1); rd_q.push_back(8'hD2);
    od_q.push_back(8'hD1);
    done_q.push_back(8'd3);
    start_xfer(1'b0, 32'h3000, 8'd4);
    seen = (x_start === 1'b1) ? 1 : 0;
    n = 0;
    while (seen < 2 && n < 200) begin
      @(negedge aclk);
      if (x_start === 1'b1) seen++;
      n++;
    end
    check("abort_second_issue_seen", seen == 2, 64'(seen), 64'd2);
    abort = 1'b1;
    wait_done(lat);
    @(negedge aclk);
    abort = 1'b0;
    repeat (8) @(negedge aclk);
    resp_delay = 1;

    // Reset while holding a byte in DELIVER, then a normal transfer.
    out_ready = 1'b0;
    xs_q.push_back(mk(32'h4000, 1'b0, 8'h00, 1'b0, 8'd2));
    rd_q.push_back(8'h77);
    start_xfer(1'b0, 32'h4000, 8'd2);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(negedge aclk);
      n++;
    end
    check("deliver_out_valid", out_valid === 1'b1, {63'd0, out_valid}, 64'd1);
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    check("reset_mid_outvalid_busy", {out_valid, busy, in_ready} == 3'b000,
          {61'd0, out_valid, busy, in_ready}, 64'd0);
    check("reset_mid_regs", x_addr == 32'h0 && res_count == 8'h0 && out_data == 8'h0,
          {24'd0, res_count, x_addr}, 64'd0);
    @(negedge aclk);
    out_ready = 1'b1;
    xs_q.push_back(mk(32'h5000, 1'b0, 8'h00, 1'b0, 8'd1));
    rd_q.push_back(8'h88);
    od_q.push_back(8'h88);
    done_q.push_back(8'd0);
    start_xfer(1'b0, 32'h5000, 8'd1);
    wait_done(lat);
    repeat (5) @(negedge aclk);

    check("xs_queue_drained", xs_q.size() == 0, 64'(xs_q.size()), 64'd0);
    check("out_queue_drained", od_q.size() == 0, 64'(od_q.size()), 64'd0);
    check("done_queue_drained", done_q.size() == 0, 64'(done_q.size()), 64'd0);
    check("read_data_consumed", rd_q.size() == 0, 64'(rd_q.size()), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
